// File: rtl/flow_pkg.sv
// Shared types, default formats and wide-arithmetic helpers for the Lucas-Kanade flow solver.
package flow_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DET,
      DIV,
      OUT
   } solver_state_t;

   localparam int ACCUM_WIDTH_DEF = 32;
   localparam int FLOW_WIDTH_DEF  = 16;
   localparam int FRAC_BITS_DEF   = 7;
   localparam int FLOW_CLAMP_DEF  = 1024;
   localparam int X_WIDTH_DEF     = 10;
   localparam int Y_WIDTH_DEF     = 9;

   // Headroom for |num| << FRAC_BITS and |det| << (FLOW_WIDTH-1) without loss.
   localparam int WIDE_W = 128;

   function automatic logic [WIDE_W-1:0] abs_wide(input logic signed [WIDE_W-1:0] x);
      return (x < 0) ? WIDE_W'(-x) : WIDE_W'(x);
   endfunction

   function automatic logic is_neg(input logic signed [WIDE_W-1:0] x);
      return x < 0;
   endfunction

endpackage

// File: rtl/flow_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// done is high during the cycle whose closing edge resolves the last bit; quotient is valid then.
module flow_serial_divider #(
   parameter int DIVIDEND_W = 72,
   parameter int DIVISOR_W  = 65,
   parameter int Q_BITS     = 15
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  done,
   output logic [Q_BITS-1:0]     quotient
);

   localparam int RW    = (DIVISOR_W + Q_BITS > DIVIDEND_W) ? DIVISOR_W + Q_BITS : DIVIDEND_W;
   localparam int CNT_W = $clog2(Q_BITS + 1);

   logic [RW-1:0]     rem_q;
   logic [RW-1:0]     dsh_q;
   logic [RW-1:0]     rem_n;
   logic [Q_BITS-1:0] quo_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              take;

   always_comb begin
      take     = rem_q >= dsh_q;
      rem_n    = take ? rem_q - dsh_q : rem_q;
      quotient = (quo_q << 1) | Q_BITS'(take);
      done     = busy_q && (cnt_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         dsh_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         rem_q  <= RW'(dividend);
         dsh_q  <= RW'(divisor) << (Q_BITS - 1);
         quo_q  <= '0;
         cnt_q  <= CNT_W'(Q_BITS - 1);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         rem_q <= rem_n;
         dsh_q <= dsh_q >> 1;
         quo_q <= quotient;
         if (cnt_q == '0)
            busy_q <= 1'b0;
         else
            cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/flow_solver_seq.sv
// Handshaked Lucas-Kanade 2x2 solver: full-precision determinant, runtime threshold, serial division.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a window
//   MUL   | six window-sum products registered
//   DET   | det / numerators formed, threshold test, divider launched
//   DIV   | serial division of |num|<<FRAC by |det|
//   OUT   | result held on flow_* until flow_ready
module flow_solver_seq
   import flow_pkg::*;
#(
   parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
   parameter int FLOW_WIDTH  = FLOW_WIDTH_DEF,
   parameter int FRAC_BITS   = FRAC_BITS_DEF,
   parameter int FLOW_CLAMP  = FLOW_CLAMP_DEF,
   parameter int X_WIDTH     = X_WIDTH_DEF,
   parameter int Y_WIDTH     = Y_WIDTH_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ACCUM_WIDTH-1:0] sum_IxIx,
   input  logic [ACCUM_WIDTH-1:0] sum_IyIy,
   input  logic [ACCUM_WIDTH-1:0] sum_IxIy,
   input  logic [ACCUM_WIDTH-1:0] sum_IxIt,
   input  logic [ACCUM_WIDTH-1:0] sum_IyIt,
   input  logic [ACCUM_WIDTH-1:0] det_threshold,
   input  logic [X_WIDTH-1:0]     pixel_x_in,
   input  logic [Y_WIDTH-1:0]     pixel_y_in,
   output logic                   flow_valid,
   input  logic                   flow_ready,
   output logic [FLOW_WIDTH-1:0]  flow_u,
   output logic [FLOW_WIDTH-1:0]  flow_v,
   output logic                   flow_reliable,
   output logic                   flow_sat,
   output logic [X_WIDTH-1:0]     pixel_x_out,
   output logic [Y_WIDTH-1:0]     pixel_y_out
);

   localparam int PW     = 2 * ACCUM_WIDTH + 1;
   localparam int Q_BITS = FLOW_WIDTH - 1;
   localparam int DVD_W  = PW + FRAC_BITS;

   solver_state_t state_q, state_n;

   logic signed [ACCUM_WIDTH-1:0]   a_xx, a_yy, a_xy, a_xt, a_yt;
   logic [ACCUM_WIDTH-1:0]          thr_q;
   logic [X_WIDTH-1:0]              px_q;
   logic [Y_WIDTH-1:0]              py_q;
   logic signed [2*ACCUM_WIDTH-1:0] p_xxyy, p_xyxy, p_xyyt, p_yyxt, p_xyxt, p_xxyt;

   logic signed [PW-1:0] det_c, nu_c, nv_c;
   logic [WIDE_W-1:0]    det_abs, nu_abs, nv_abs, dvd_u, dvd_v, det_lim;
   logic                 solvable_c, ovf_u_c, ovf_v_c;
   logic                 neg_u_q, neg_v_q, ovf_u_q, ovf_v_q;

   logic                 div_start, done_u, done_v;
   logic [Q_BITS-1:0]    q_u, q_v;
   logic                 clip_u, clip_v;
   logic [FLOW_WIDTH-1:0] mag_u, mag_v;

   always_comb begin
      det_c      = PW'(p_xxyy) - PW'(p_xyxy);
      nu_c       = PW'(p_xyyt) - PW'(p_yyxt);
      nv_c       = PW'(p_xyxt) - PW'(p_xxyt);
      det_abs    = abs_wide(WIDE_W'(det_c));
      nu_abs     = abs_wide(WIDE_W'(nu_c));
      nv_abs     = abs_wide(WIDE_W'(nv_c));
      solvable_c = det_abs > WIDE_W'(thr_q);
      dvd_u      = nu_abs << FRAC_BITS;
      dvd_v      = nv_abs << FRAC_BITS;
      // A quotient that cannot fit Q_BITS is caught here, before the divider runs.
      det_lim    = det_abs << Q_BITS;
      ovf_u_c    = dvd_u >= det_lim;
      ovf_v_c    = dvd_v >= det_lim;
      clip_u     = ovf_u_q || (int'(q_u) > FLOW_CLAMP);
      clip_v     = ovf_v_q || (int'(q_v) > FLOW_CLAMP);
      mag_u      = clip_u ? FLOW_WIDTH'(FLOW_CLAMP) : FLOW_WIDTH'(q_u);
      mag_v      = clip_v ? FLOW_WIDTH'(FLOW_CLAMP) : FLOW_WIDTH'(q_v);
   end

   always_comb begin
      state_n    = state_q;
      in_ready   = 1'b0;
      flow_valid = 1'b0;
      div_start  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = MUL;
         end
         MUL: state_n = DET;
         DET: begin
            if (solvable_c) begin
               div_start = 1'b1;
               state_n   = DIV;
            end else begin
               state_n = OUT;
            end
         end
         DIV: if (done_u && done_v) state_n = OUT;
         OUT: begin
            flow_valid = 1'b1;
            if (flow_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {a_xx, a_yy, a_xy, a_xt, a_yt} <= '0;
         thr_q <= '0;
         px_q  <= '0;
         py_q  <= '0;
         {p_xxyy, p_xyxy, p_xyyt, p_yyxt, p_xyxt, p_xxyt} <= '0;
         {neg_u_q, neg_v_q, ovf_u_q, ovf_v_q} <= '0;
         flow_u        <= '0;
         flow_v        <= '0;
         flow_reliable <= 1'b0;
         flow_sat      <= 1'b0;
         pixel_x_out   <= '0;
         pixel_y_out   <= '0;
      end else begin
         if (in_ready && in_valid) begin
            a_xx  <= $signed(sum_IxIx);
            a_yy  <= $signed(sum_IyIy);
            a_xy  <= $signed(sum_IxIy);
            a_xt  <= $signed(sum_IxIt);
            a_yt  <= $signed(sum_IyIt);
            thr_q <= det_threshold;
            px_q  <= pixel_x_in;
            py_q  <= pixel_y_in;
         end
         if (state_q == MUL) begin
            p_xxyy <= a_xx * a_yy;
            p_xyxy <= a_xy * a_xy;
            p_xyyt <= a_xy * a_yt;
            p_yyxt <= a_yy * a_xt;
            p_xyxt <= a_xy * a_xt;
            p_xxyt <= a_xx * a_yt;
         end
         if (state_q == DET) begin
            neg_u_q <= is_neg(WIDE_W'(nu_c)) ^ is_neg(WIDE_W'(det_c));
            neg_v_q <= is_neg(WIDE_W'(nv_c)) ^ is_neg(WIDE_W'(det_c));
            ovf_u_q <= ovf_u_c;
            ovf_v_q <= ovf_v_c;
            if (!solvable_c) begin
               flow_u        <= '0;
               flow_v        <= '0;
               flow_reliable <= 1'b0;
               flow_sat      <= 1'b0;
               pixel_x_out   <= px_q;
               pixel_y_out   <= py_q;
            end
         end
         if (state_q == DIV && done_u && done_v) begin
            flow_u        <= neg_u_q ? -mag_u : mag_u;
            flow_v        <= neg_v_q ? -mag_v : mag_v;
            flow_reliable <= 1'b1;
            flow_sat      <= clip_u | clip_v;
            pixel_x_out   <= px_q;
            pixel_y_out   <= py_q;
         end
      end
   end

   flow_serial_divider #(.DIVIDEND_W(DVD_W), .DIVISOR_W(PW), .Q_BITS(Q_BITS)) u_div_u (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (dvd_u[DVD_W-1:0]),
      .divisor  (det_abs[PW-1:0]),
      .done     (done_u),
      .quotient (q_u)
   );

   flow_serial_divider #(.DIVIDEND_W(DVD_W), .DIVISOR_W(PW), .Q_BITS(Q_BITS)) u_div_v (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (dvd_v[DVD_W-1:0]),
      .divisor  (det_abs[PW-1:0]),
      .done     (done_v),
      .quotient (q_v)
   );

endmodule

// File: tb/tb_flow_solver_seq.sv
// Directed-vector bench for flow_solver_seq: table of windows plus back-pressure and reset-abort sequences.
module tb_flow_solver_seq;

   localparam int AW = 32;
   localparam int FW = 16;
   localparam int XW = 10;
   localparam int YW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] sum_IxIx = '0, sum_IyIy = '0, sum_IxIy = '0, sum_IxIt = '0, sum_IyIt = '0;
   logic [AW-1:0] det_threshold = '0;
   logic [XW-1:0] pixel_x_in = '0;
   logic [YW-1:0] pixel_y_in = '0;
   logic          flow_valid;
   logic          flow_ready = 1'b1;
   logic [FW-1:0] flow_u, flow_v;
   logic          flow_reliable, flow_sat;
   logic [XW-1:0] pixel_x_out;
   logic [YW-1:0] pixel_y_out;

   always #5 clk = ~clk;

   flow_solver_seq dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .sum_IxIx      (sum_IxIx),
      .sum_IyIy      (sum_IyIy),
      .sum_IxIy      (sum_IxIy),
      .sum_IxIt      (sum_IxIt),
      .sum_IyIt      (sum_IyIt),
      .det_threshold (det_threshold),
      .pixel_x_in    (pixel_x_in),
      .pixel_y_in    (pixel_y_in),
      .flow_valid    (flow_valid),
      .flow_ready    (flow_ready),
      .flow_u        (flow_u),
      .flow_v        (flow_v),
      .flow_reliable (flow_reliable),
      .flow_sat      (flow_sat),
      .pixel_x_out   (pixel_x_out),
      .pixel_y_out   (pixel_y_out)
   );

   typedef struct {
      int          ixix, iyiy, ixiy, ixit, iyit;
      int unsigned thr;
      int          px, py;
      int          eu, ev;
      int          erel, esat, elat;
   } vec_t;

   vec_t vecs[8];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      sum_IxIx      = AW'(v.ixix);
      sum_IyIy      = AW'(v.iyiy);
      sum_IxIy      = AW'(v.ixiy);
      sum_IxIt      = AW'(v.ixit);
      sum_IyIt      = AW'(v.iyit);
      det_threshold = v.thr;
      pixel_x_in    = XW'(v.px);
      pixel_y_in    = YW'(v.py);
   endtask

   // Counts negedges after the accept edge until flow_valid is seen; -1 on timeout.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (flow_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input vec_t v);
      chk({tag, "_u"},   longint'($signed(flow_u)), v.eu);
      chk({tag, "_v"},   longint'($signed(flow_v)), v.ev);
      chk({tag, "_rel"}, flow_reliable, v.erel);
      chk({tag, "_sat"}, flow_sat, v.esat);
      chk({tag, "_px"},  pixel_x_out, v.px);
      chk({tag, "_py"},  pixel_y_out, v.py);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int lat;
      @(negedge clk);
      drive(v);
      flow_ready = 1'b1;
      in_valid   = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      wait_valid(lat);
      chk({tag, "_latency"}, lat, v.elat);
      if (lat > 0) begin
         check_result(tag, v);
         @(posedge clk);
      end
   endtask

   initial begin
      int   lat;
      bit   seen;
      vec_t bp;

      //            ixix  iyiy ixiy  ixit     iyit  thr   px    py    u     v     rel sat lat
      vecs[0] = '{100,  100, 0,    -200,    100,  1000, 12,   34,   256,  -128, 1,  0,  18};
      vecs[1] = '{30,   30,  0,    5,       7,    1000, 1023, 511,  0,    0,    0,  0,  3};
      vecs[2] = '{100,  100, 0,    -2000,   2000, 1000, 5,    6,    1024, -1024,1,  1,  18};
      vecs[3] = '{10,   10,  40,   3,       0,    1000, 100,  200,  2,    -10,  1,  0,  18};
      vecs[4] = '{100,  100, 0,    -800,    0,    0,    513,  257,  1024, 0,    1,  0,  18};
      vecs[5] = '{30,   30,  0,    1,       1,    900,  7,    8,    0,    0,    0,  0,  3};
      vecs[6] = '{1,    1,   0,    -100000, 5,    0,    9,    10,   1024, -640, 1,  1,  18};
      vecs[7] = '{50,   20,  10,   7,       -3,   899,  300,  400,  -24,  31,   1,  0,  18};

      #1;
      chk("rst_in_ready",   in_ready, 1);
      chk("rst_flow_valid", flow_valid, 0);
      chk("rst_flow_u",     flow_u, 0);
      chk("rst_flow_v",     flow_v, 0);
      chk("rst_reliable",   flow_reliable, 0);
      chk("rst_sat",        flow_sat, 0);
      chk("rst_px",         pixel_x_out, 0);
      chk("rst_py",         pixel_y_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run_vec($sformatf("vec%0d", i), vecs[i]);

      // Back-pressure: result and coordinates held while flow_ready low; new in_valid ignored.
      bp    = vecs[0];
      bp.px = 777;
      bp.py = 333;
      @(negedge clk);
      drive(bp);
      flow_ready = 1'b0;
      in_valid   = 1'b1;
      @(posedge clk);
      wait_valid(lat);
      chk("bp_latency", lat, 18);
      sum_IxIt = AW'(12345);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_valid", k), flow_valid, 1);
         chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
         check_result($sformatf("bp%0d", k), bp);
         @(negedge clk);
      end
      in_valid   = 1'b0;
      flow_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_valid", flow_valid, 0);

      // Reset during DIV aborts the window.
      drive(vecs[0]);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_flow_u",   flow_u, 0);
      chk("mid_rst_flow_v",   flow_v, 0);
      chk("mid_rst_valid",    flow_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_reliable", flow_reliable, 0);
      chk("mid_rst_px",       pixel_x_out, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (flow_valid) seen = 1'b1;
      end
      chk("aborted_window_valid", seen, 0);
      run_vec("post_rst", vecs[7]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/flow_solver_seq.md
Name: flow_solver_seq

Overview:
Handshaked successor to the single-cycle Lucas-Kanade 2x2 solver.
- Full-precision determinant and numerators, with the correct LK sign convention.
- Runtime determinant threshold.
- Multi-cycle serial division instead of a combinational divider; saturation and reliability flags.
- Sits between the window accumulator and the flow output/packer stage; back-pressure on both sides.

Parameters:
ACCUM_WIDTH, 32, width of each signed window sum
FLOW_WIDTH, 16, signed flow output width (S8.7 at default)
FRAC_BITS, 7, fractional bits of flow outputs
FLOW_CLAMP, 1024, symmetric output clamp magnitude (±8.0 px at default)
X_WIDTH, 10, pixel x coordinate width
Y_WIDTH, 9, pixel y coordinate width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  window sums and coordinates valid
in_ready  out  1  solver can accept a new window
sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt  in  ACCUM_WIDTH each  signed window sums
det_threshold  in  ACCUM_WIDTH  unsigned; sampled on accept
pixel_x_in / pixel_y_in  in  X_WIDTH / Y_WIDTH  window centre
flow_valid  out  1  result valid
flow_ready  in  1  downstream accepts result
flow_u, flow_v  out  FLOW_WIDTH  signed flow, FRAC_BITS fractional
flow_reliable  out  1  |det| > threshold
flow_sat  out  1  u or v was clamped
pixel_x_out / pixel_y_out  out  X_WIDTH / Y_WIDTH  coordinates of result

Behaviour:
- Reset (async, active-high):
  - State IDLE, in_ready=1, flow_valid=0.
  - flow_u, flow_v, flow_reliable, flow_sat and pixel_*_out all 0.
  - Reset mid-operation aborts the window; no flow_valid is ever produced for it.
- Accept: in_valid & in_ready on an edge. All inputs are latched on that edge. in_ready=1 only in IDLE, so one window is in flight at a time.
- FSM: IDLE -> MUL -> DET -> DIV -> OUT -> IDLE; DET -> OUT when the system is unsolvable.
  - MUL (1 cycle): six products, each 2*ACCUM_WIDTH bits, registered.
  - DET (1 cycle):
    - det = IxIx*IyIy - IxIy^2
    - num_u = IxIy*IyIt - IyIy*IxIt
    - num_v = IxIy*IxIt - IxIx*IyIt
    - All three are 2*ACCUM_WIDTH+1 bits. No truncation.
    - solvable = |det| > det_threshold (strict).
    - If not solvable: u=v=0, reliable=0, sat=0, go to OUT.
  - DIV (FLOW_WIDTH-1 cycles):
    - Magnitudes go to two parallel dividers with a shared divisor: dividend |num|<<FRAC_BITS, divisor |det|.
    - Pre-check on DIV entry: if dividend >= |det|<<(FLOW_WIDTH-1), that component is overflowed and forced to FLOW_CLAMP magnitude.
    - Result sign = sign(num) XOR sign(det). Quotient truncates toward zero; num=0 gives 0.
    - Clamp to ±FLOW_CLAMP. flow_sat=1 if either component clamped. reliable=1.
  - OUT: flow_valid=1. All outputs are held stable until flow_ready. On flow_valid & flow_ready, return to IDLE; in_ready=1 the next cycle.
- Latency (accept edge to flow_valid):
  - Solvable: 3+(FLOW_WIDTH-1) cycles, 18 at default.
  - Unsolvable: 3 cycles.
- flow_ready high before flow_valid has no effect.
- in_valid while in_ready=0 is ignored; the upstream stage holds its data.

Decomposition:
- flow_pkg:
  - solver_state_t enum (IDLE, MUL, DET, DIV, OUT)
  - default Q-format constants
  - FLOW_CLAMP default
  - abs/sign helper functions
- Sub-module flow_serial_divider:
  - Unsigned restoring divider with start/done handshake.
  - Parameters DIVIDEND_W, DIVISOR_W, Q_BITS; one quotient bit per cycle, MSB first.
  - Instantiated twice, for u and v.

Test Plan:
- Basic solve: IxIx=100, IyIy=100, IxIy=0, IxIt=-200, IyIt=100, thr=1000 -> u=256, v=-128, reliable=1, sat=0, flow_valid 18 cycles after accept.
- Threshold reject: IxIx=30, IyIy=30, IxIy=0 (det=900), thr=1000 -> u=v=0, reliable=0, flow_valid 3 cycles after accept.
- Saturation: IxIx=100, IyIy=100, IxIy=0, IxIt=-2000, IyIt=2000 -> u=1024, v=-1024, sat=1, reliable=1.
- Negative det / truncation: IxIx=10, IyIy=10, IxIy=40 (det=-1500), IxIt=3, IyIt=0 -> u=2, v=-10.
- Back-pressure: flow_ready=0 for 5 cycles after flow_valid -> outputs and coordinates stable, in_ready=0 throughout; flow_ready=1 -> in_ready=1 the next cycle.
- Reset mid-DIV: assert rst 8 cycles after accept -> all outputs 0 immediately; after release in_ready=1, no flow_valid for the aborted window; the next window solves correctly.
